clock_controller: RTL and testbench
===================================

# clock_controller

Time-keeping controller for the digital clock. It sequences the seconds, minutes and hours counters from a 1 Hz tick and runs the user set-mode state machine driven by two pre-debounced buttons. It sits between the tick prescaler and button debouncers on the input side and the display decoders on the output side.

## Interface
- `HOUR_MOD`, default 24: hour modulus; hours count 0..HOUR_MOD-1; legal range 2..32.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle 1 Hz pulse from the prescaler.
- `btn_mode`  in  1  debounced level; each rising edge advances the mode.
- `btn_inc`  in  1  debounced level; each rising edge increments the field being set.
- `second`  out  6  seconds, 0..59.
- `minute`  out  6  minutes, 0..59.
- `hour`  out  5  hours, 0..HOUR_MOD-1.
- `mode`  out  2  current state (mode_t encoding).
- `blink`  out  1  display blank phase for the field being set.
- `day_pulse`  out  1  one-cycle pulse on hour rollover in RUN.

## Operation
- Reset, with `rst`=1 at a posedge: second/minute/hour=0, mode=RUN, blink=0, day_pulse=0. Both button history registers are set to 1, so a button held through reset gives no edge.
- Edge detect: `mode_edge` = btn_mode & ~btn_mode_q. `inc_edge` is built the same way. Each history register is updated every cycle.
- State machine mode_t:
  - RUN(0) goes to SET_HOUR(1) on mode_edge.
  - SET_HOUR goes to SET_MIN(2) on mode_edge.
  - SET_MIN goes to RUN on mode_edge.
  - Encoding 3 is unreachable. If it ever occurs, the next cycle goes to RUN.
- RUN:
  - tick increments second.
  - second wrap (59 to 0) increments minute.
  - minute wrap increments hour.
  - hour wrap (HOUR_MOD-1 to 0) asserts day_pulse for that cycle.
  - inc_edge is ignored.
- SET_HOUR:
  - tick does not advance time.
  - inc_edge increments hour modulo HOUR_MOD, with no day_pulse.
  - second and minute hold.
- SET_MIN:
  - tick does not advance time.
  - inc_edge increments minute modulo 60, with no carry into hour.
  - second holds.
- blink:
  - Forced to 0 in RUN and on every mode change.
  - In a set state, it toggles on each tick.
  - It is forced to 0 on inc_edge, so the field is shown immediately after a change.
- Simultaneous events:
  - mode_edge together with inc_edge: the mode change wins and the increment is dropped.
  - mode_edge together with tick in RUN: the tick is applied (full carry chain) and the mode moves to SET_HOUR in the same cycle.
- Arithmetic: the counters never exceed MOD-1. Carries ripple combinationally within one cycle.

## Timing
- All outputs are registered.
- tick at posedge N: the updated time is visible after posedge N. 23:59:59 goes to 00:00:00 in a single cycle, with day_pulse high for exactly that cycle.
- Button rising edge sampled at posedge N: mode or field updates after posedge N. Latency is 1 cycle from the sampled level.
- A held button gives exactly one action. Re-trigger needs a low sample first.
- `rst` mid-operation overrides everything in the same cycle, including a coincident tick or edge.

## Configuration
- `CLOCK_SEC_CLEAR_EN`:
  - Defined: the SET_MIN to RUN transition also clears second to 0. Any tick coincident with that transition is dropped, so second=0 after the edge.
  - Undefined: second keeps its frozen value on returning to RUN, and counting resumes from there.

## Structure
- Package `clock_pkg`:
  - `mode_t` enum (MODE_RUN=0, MODE_SET_HOUR=1, MODE_SET_MIN=2), 2-bit.
  - Constants `SEC_MOD`=60 and `MIN_MOD`=60.
  - Field width constants 6/6/5.
- Sub-module `mod_counter #(WIDTH, MOD)`:
  - Ports: clk, rst, en, clr, value, wrap.
  - wrap = en & (value==MOD-1), combinational.
  - clr has priority over en.
  - Instantiate it three times; the controller drives en/clr.

## Test plan
- Reset, then 59 ticks: second=59, minute=0. One more tick: second=0, minute=1.
- Preload via set mode to 23:59, run to :59, then one tick: 00:00:00 and day_pulse high for exactly 1 cycle.
- Three btn_mode pulses: mode 0 to 1 to 2 to 0. In SET_HOUR, 25 btn_inc pulses give hour=1 (HOUR_MOD=24) and day_pulse stays 0.
- In SET_MIN, tick pulses leave time unchanged. blink toggles per tick, reads 0 right after each inc_edge, and reads 0 back in RUN.
- btn_mode and btn_inc rising in the same cycle while in SET_HOUR: mode becomes SET_MIN and hour is unchanged.
- btn_mode held high through reset release: mode stays RUN. Then `rst` asserted mid-SET_MIN with a coincident tick: all outputs 0, mode RUN. With `CLOCK_SEC_CLEAR_EN`, exit SET_MIN from second=37: second=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-keeping slice.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the MOD-1 -> 0 step.
module mod_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MOD   = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] value_q;

    assign value = value_q;
    // Combinational so the next stage can carry in the same cycle.
    assign wrap  = en & (value_q == MaxVal);

    // Count register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (en) begin
            value_q <= wrap ? '0 : value_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_controller.sv
// Time-keeping controller: seconds/minutes/hours chain plus set-mode FSM.
// Optional feature: define CLOCK_SEC_CLEAR_EN to clear seconds when leaving SET_MIN.
module clock_controller
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [SEC_W-1:0]  second,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic [1:0]        mode,
    output logic              blink,
    output logic              day_pulse
);

    mode_t mode_q, mode_d;
    logic  btn_mode_q, btn_inc_q;
    logic  blink_q, blink_d;
    logic  day_pulse_q, day_pulse_d;

    logic  mode_edge, inc_edge;
    logic  sec_en, min_en, hour_en, sec_clr;
    logic  sec_wrap, min_wrap, hour_wrap;

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc & ~btn_inc_q;

    mod_counter #(.WIDTH(SEC_W), .MOD(SEC_MOD)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_en),
        .clr   (sec_clr),
        .value (second),
        .wrap  (sec_wrap)
    );

    mod_counter #(.WIDTH(MIN_W), .MOD(MIN_MOD)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .clr   (1'b0),
        .value (minute),
        .wrap  (min_wrap)
    );

    mod_counter #(.WIDTH(HOUR_W), .MOD(HOUR_MOD)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (hour_en),
        .clr   (1'b0),
        .value (hour),
        .wrap  (hour_wrap)
    );

    // State, button history and registered flags; history resets high so a held button is inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_RUN;
            btn_mode_q  <= 1'b1;
            btn_inc_q   <= 1'b1;
            blink_q     <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            blink_q     <= blink_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    // Next mode and counter enables; a mode edge always suppresses a coincident increment.
    always_comb begin
        mode_d      = mode_q;
        sec_en      = 1'b0;
        min_en      = 1'b0;
        hour_en     = 1'b0;
        sec_clr     = 1'b0;
        day_pulse_d = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                sec_en      = tick;
                min_en      = sec_wrap;
                hour_en     = min_wrap;
                day_pulse_d = hour_wrap;
                if (mode_edge) mode_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (mode_edge) mode_d = MODE_SET_MIN;
                else           hour_en = inc_edge;
            end
            MODE_SET_MIN: begin
                if (mode_edge) begin
                    mode_d = MODE_RUN;
`ifdef CLOCK_SEC_CLEAR_EN
                    sec_clr = 1'b1;
`endif
                end else begin
                    min_en = inc_edge;
                end
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    // Blink phase: toggles per tick while setting, shows the field on any change.
    always_comb begin
        blink_d = blink_q;
        if (mode_d != mode_q || mode_q == MODE_RUN) begin
            blink_d = 1'b0;
        end else if (inc_edge) begin
            blink_d = 1'b0;
        end else if (tick) begin
            blink_d = ~blink_q;
        end
    end

    assign mode      = mode_q;
    assign blink     = blink_q;
    assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed self-checking bench for clock_controller (HOUR_MOD = 24).
module tb_clock_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int dp_count = 0;
    int dp_before;
    int exp_sec;

    clock_controller #(.HOUR_MOD(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .second    (second),
        .minute    (minute),
        .hour      (hour),
        .mode      (mode),
        .blink     (blink),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    // Count day pulses as seen at sample time.
    always @(negedge clk) if (!rst && day_pulse) dp_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic press_mode();
        @(negedge clk) btn_mode = 1'b1;
        @(negedge clk) btn_mode = 1'b0;
    endtask

    task automatic press_inc();
        @(negedge clk) btn_inc = 1'b1;
        @(negedge clk) btn_inc = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, 32'(hour), 32'(h));
        check({tag, "_min"}, 32'(minute), 32'(m));
        check({tag, "_sec"}, 32'(second), 32'(s));
    endtask

    initial begin
        // Reset with btn_mode held high across release.
        rst = 1'b1; tick = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("held_mode_after_rst", 32'(mode), 0);
        btn_mode = 1'b0;
        @(negedge clk);
        check_time("reset", 0, 0, 0);
        check("reset_blink", 32'(blink), 0);
        check("reset_day_pulse", 32'(day_pulse), 0);

        // Seconds carry into minutes.
        repeat (59) pulse_tick();
        check_time("t59", 0, 0, 59);
        pulse_tick();
        check_time("t60", 0, 1, 0);

        // Increment ignored in RUN.
        press_inc();
        check_time("run_inc_ignored", 0, 1, 0);

        // SET_HOUR: 25 increments wrap modulo 24 without a day pulse.
        press_mode();
        check("mode_set_hour", 32'(mode), 1);
        dp_before = dp_count;
        repeat (25) press_inc();
        check("set_hour_wrap", 32'(hour), 1);
        check("set_hour_no_day_pulse", 32'(dp_count - dp_before), 0);
        repeat (22) press_inc();
        check("set_hour_23", 32'(hour), 23);

        // SET_MIN: ticks freeze time and toggle blink; inc clears blink.
        press_mode();
        check("mode_set_min", 32'(mode), 2);
        check("blink_on_entry", 32'(blink), 0);
        pulse_tick();
        check("blink_tick1", 32'(blink), 1);
        pulse_tick();
        check("blink_tick2", 32'(blink), 0);
        pulse_tick();
        check("blink_tick3", 32'(blink), 1);
        check_time("set_min_frozen", 23, 1, 0);
        press_inc();
        check("blink_after_inc", 32'(blink), 0);
        check("set_min_inc", 32'(minute), 2);
        repeat (57) press_inc();
        check_time("set_min_59", 23, 59, 0);

        // Back to RUN, roll the day over.
        press_mode();
        check("mode_run", 32'(mode), 0);
        check("blink_run", 32'(blink), 0);
        repeat (59) pulse_tick();
        check_time("pre_rollover", 23, 59, 59);
        dp_before = dp_count;
        pulse_tick();
        check_time("rollover", 0, 0, 0);
        check("rollover_day_pulse", 32'(day_pulse), 1);
        @(negedge clk);
        check("day_pulse_drop", 32'(day_pulse), 0);
        check("day_pulse_count", 32'(dp_count - dp_before), 1);

        // Mode edge with inc edge in SET_HOUR: mode wins.
        press_mode();
        press_inc();
        check("set_hour_1", 32'(hour), 1);
        @(negedge clk) begin btn_mode = 1'b1; btn_inc = 1'b1; end
        @(negedge clk) begin btn_mode = 1'b0; btn_inc = 1'b0; end
        check("simul_mode", 32'(mode), 2);
        check("simul_hour", 32'(hour), 1);

        // Mode edge with tick in RUN: tick applied, mode advances.
        press_mode();
        check("mode_run2", 32'(mode), 0);
        repeat (36) pulse_tick();
        @(negedge clk) begin btn_mode = 1'b1; tick = 1'b1; end
        @(negedge clk) begin btn_mode = 1'b0; tick = 1'b0; end
        check("tick_mode_mode", 32'(mode), 1);
        check_time("tick_mode_time", 1, 0, 37);

        // Leave SET_MIN from second 37.
        press_mode();
        check("mode_set_min2", 32'(mode), 2);
        press_mode();
`ifdef CLOCK_SEC_CLEAR_EN
        exp_sec = 0;
`else
        exp_sec = 37;
`endif
        check("exit_set_min_mode", 32'(mode), 0);
        check("exit_set_min_sec", 32'(second), 32'(exp_sec));
        pulse_tick();
        check("resume_sec", 32'(second), 32'(exp_sec + 1));

        // Reset mid-SET_MIN with coincident tick.
        press_mode();
        press_mode();
        check("mode_set_min3", 32'(mode), 2);
        pulse_tick();
        check("blink_pre_rst", 32'(blink), 1);
        @(negedge clk) begin rst = 1'b1; tick = 1'b1; end
        @(negedge clk) begin rst = 1'b0; tick = 1'b0; end
        check_time("mid_rst", 0, 0, 0);
        check("mid_rst_mode", 32'(mode), 0);
        check("mid_rst_blink", 32'(blink), 0);
        check("mid_rst_day_pulse", 32'(day_pulse), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
